// File: rtl/icache_2way_ro_pkg.sv
// Shared constants and FSM encoding for the 2-way read-only instruction cache.
package icache_2way_ro_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int ADDR_W          = 30;
    localparam int BLK_ADDR_W      = 28;

    typedef enum logic {
        IDLE  = 1'b0,
        ALLOC = 1'b1
    } state_t;

endpackage

// File: rtl/icache_way_array.sv
// One cache way: valid/tag/data storage with a combinational lookup port
// and a synchronous whole-block fill port.
module icache_way_array
    import icache_2way_ro_pkg::*;
#(
    parameter int SETS  = 4,
    parameter int IDX_W = 2,
    parameter int TAG_W = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   lk_idx,
    input  logic [TAG_W-1:0]   lk_tag,
    input  logic [1:0]         lk_off,
    output logic               lk_valid,
    output logic               lk_hit,
    output logic [WORD_W-1:0]  lk_word,
    input  logic               fill_en,
    input  logic [IDX_W-1:0]   fill_idx,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data
);

    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [TAG_W-1:0]   tag_d  [SETS];
    logic [BLOCK_W-1:0] data_q [SETS];
    logic [BLOCK_W-1:0] data_d [SETS];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = fill_data;
        end
    end

    assign lk_valid = valid_q[lk_idx];
    assign lk_hit   = lk_valid && (tag_q[lk_idx] == lk_tag);
    assign lk_word  = data_q[lk_idx][{lk_off, 5'd0} +: WORD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data carry no reset; a cleared valid bit masks whatever they hold.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/icache_2way_ro.sv
// 2-way set-associative read-only L1 instruction cache: single-cycle hits,
// blocking 4-word fill on a miss with per-set LRU replacement.
module icache_2way_ro
    import icache_2way_ro_pkg::*;
#(
    parameter int SETS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  proc_read,
    input  logic                  proc_write,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [WORD_W-1:0]     proc_wdata,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  proc_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BLK_ADDR_W-1:0] mem_addr,
    output logic [BLOCK_W-1:0]    mem_wdata,
    input  logic [BLOCK_W-1:0]    mem_rdata,
    input  logic                  mem_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = BLK_ADDR_W - IDX_W;

    // No write path exists; these inputs are intentionally sunk.
    logic unused_inputs;
    assign unused_inputs = ^{proc_write, proc_wdata};

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [1:0]       lk_off;
    assign lk_off = proc_addr[1:0];
    assign lk_idx = proc_addr[IDX_W+1:2];
    assign lk_tag = proc_addr[ADDR_W-1:IDX_W+2];

    state_t           state_q, state_d;
    logic             victim_q, victim_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [SETS-1:0]  lru_q, lru_d;

    logic              valid0, valid1, hit0, hit1, fill_en;
    logic [WORD_W-1:0] word0, word1;

    icache_way_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way0 (
        .clk(clk), .rst(rst),
        .lk_idx(lk_idx), .lk_tag(lk_tag), .lk_off(lk_off),
        .lk_valid(valid0), .lk_hit(hit0), .lk_word(word0),
        .fill_en(fill_en && !victim_q), .fill_idx(miss_idx_q),
        .fill_tag(miss_tag_q), .fill_data(mem_rdata)
    );

    icache_way_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way1 (
        .clk(clk), .rst(rst),
        .lk_idx(lk_idx), .lk_tag(lk_tag), .lk_off(lk_off),
        .lk_valid(valid1), .lk_hit(hit1), .lk_word(word1),
        .fill_en(fill_en && victim_q), .fill_idx(miss_idx_q),
        .fill_tag(miss_tag_q), .fill_data(mem_rdata)
    );

    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        lru_d      = lru_q;
        fill_en    = 1'b0;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_addr   = proc_addr[ADDR_W-1:2];
        case (state_q)
            IDLE: begin
                if (proc_read) begin
                    if (hit0 || hit1) begin
                        proc_rdata    = hit0 ? word0 : word1;
                        lru_d[lk_idx] = hit0;
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = ALLOC;
                        miss_idx_d = lk_idx;
                        miss_tag_d = lk_tag;
                        // Fill an empty way first (way0 preferred), else evict the LRU way.
                        if (!valid0) begin
                            victim_d = 1'b0;
                        end else if (!valid1) begin
                            victim_d = 1'b1;
                        end else begin
                            victim_d = lru_q[lk_idx];
                        end
                    end
                end
            end
            ALLOC: begin
                mem_read   = 1'b1;
                proc_stall = 1'b1;
                mem_addr   = {miss_tag_q, miss_idx_q};
                if (mem_ready) begin
                    fill_en           = 1'b1;
                    lru_d[miss_idx_q] = !victim_q;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            victim_q   <= 1'b0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            lru_q      <= lru_d;
        end
    end

endmodule
